// File: rtl/mmio_responder.sv
// MMIO responder for the 0xA region: a UART TX FIFO drained through a byte
// stream port, and a prescaled 64-bit timer whose high word is snapshotted on a TIME_LO read.
module mmio_responder #(
    parameter int unsigned RESP_LAT   = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PRESCALE   = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        ready_to_read,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [3:0]    LAT     = 4'(RESP_LAT);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    localparam logic [9:0] OFF_UART_DATA = 10'h0FE;
    localparam logic [9:0] OFF_UART_STAT = 10'h0FF;
    localparam logic [9:0] OFF_TIME_LO   = 10'h012;
    localparam logic [9:0] OFF_TIME_HI   = 10'h013;

    typedef enum logic [1:0] {IDLE, WAIT, EXEC, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        wr_q, wr_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  size_q, size_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [63:0] timer_q, timer_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [31:0] shadow_q, shadow_d;
    logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [7:0]  fifo_mem_q [FIFO_DEPTH];

    logic        fifo_full, fifo_empty, push, pop, in_region;
    logic [AW:0] fifo_cnt;
    logic [9:0]  off;
    logic [31:0] exec_rdata;
    logic        unused_bits;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign fifo_cnt   = wptr_q - rptr_q;
    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo_empty ? 8'h00 : fifo_mem_q[rptr_q[AW-1:0]];
    assign pop        = tx_valid && tx_ready;

    assign in_region     = (addr_q[31:28] == 4'hA);
    assign off           = addr_q[11:2];
    assign resp_valid    = (state_q == RESP);
    assign resp_rdata    = rdata_q;
    assign ready_to_read = (state_q == IDLE);
    assign unused_bits   = ^{size_q, addr_q[63:32], addr_q[27:12], addr_q[1:0], wdata_q[31:8]};

    always_comb begin
        exec_rdata = 32'h0;
        if (in_region && !wr_q) begin
            case (off)
                OFF_UART_STAT: exec_rdata = {16'h0, 8'(fifo_cnt), 5'h0, err_q, fifo_empty, fifo_full};
                OFF_TIME_LO:   exec_rdata = timer_q[31:0];
                OFF_TIME_HI:   exec_rdata = shadow_q;
                default:       exec_rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        shadow_d = shadow_q;
        push     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    wcnt_d  = LAT;
                    state_d = (LAT != 4'd0) ? WAIT : EXEC;
                end
            end
            WAIT: begin
                wcnt_d = wcnt_q - 4'd1;
                if (wcnt_q <= 4'd1) state_d = EXEC;
            end
            EXEC: begin
                // A full FIFO only accepts the push in a cycle that also pops.
                if (in_region && wr_q && off == OFF_UART_DATA && fifo_full && !pop) begin
                    state_d = EXEC;
                end else begin
                    state_d = RESP;
                    rdata_d = exec_rdata;
                    if (!in_region) err_d = 1'b1;
                    else if (wr_q && off == OFF_UART_DATA) push = 1'b1;
                    else if (!wr_q && off == OFF_TIME_LO) shadow_d = timer_q[63:32];
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wptr_d  = wptr_q + (AW + 1)'(push);
        rptr_d  = rptr_q + (AW + 1)'(pop);
        pre_d   = pre_q + PW'(1);
        timer_d = timer_q;
        if (pre_q == PRE_MAX) begin
            pre_d   = '0;
            timer_d = timer_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            size_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            timer_q  <= '0;
            pre_q    <= '0;
            shadow_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
            pre_q    <= pre_d;
            shadow_q <= shadow_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wptr_q[AW-1:0]] <= wdata_q[7:0];
    end
endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: register vector table plus hand-written
// sequences for FIFO backpressure, wrong-region errors, mid-transaction reset and the timer.
module tb_mmio_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_size = 4'd4;
    logic        resp_valid, ready_to_read, tx_valid;
    logic [31:0] resp_rdata;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;

    int passed = 0;
    int total  = 0;

    mmio_responder #(.RESP_LAT(1), .FIFO_DEPTH(16), .PRESCALE(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .ready_to_read(ready_to_read),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One full handshake; lat counts cycles from the accept edge to resp_valid (0 = timed out).
    task automatic xact(input logic w, input logic [63:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        lat = 0;
        rd  = 32'hDEAD_BEEF;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = n;
                rd  = resp_rdata;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          seen;
        logic [7:0]  exp_b;

        vt[0] = '{1'b0, 64'hA000_03FC, 32'h0,      32'h0000_0002};
        vt[1] = '{1'b1, 64'hA000_03F8, 32'h41,     32'h0};
        vt[2] = '{1'b0, 64'hA000_03FC, 32'h0,      32'h0000_0100};
        vt[3] = '{1'b0, 64'hA000_03F8, 32'h0,      32'h0};
        vt[4] = '{1'b1, 64'hA000_004C, 32'hFFFF,   32'h0};
        vt[5] = '{1'b0, 64'hA000_0100, 32'h0,      32'h0};
        vt[6] = '{1'b1, 64'hA000_03FC, 32'h123,    32'h0};
        vt[7] = '{1'b0, 64'hA000_03FF, 32'h0,      32'h0000_0100};

        // Reset state
        #12;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", 64'(resp_rdata), 64'd0);
        chk("rst_tx_valid", 64'(tx_valid), 64'd0);
        chk("rst_tx_data", 64'(tx_data), 64'd0);
        chk("rst_ready", 64'(ready_to_read), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            xact(vt[i].w, vt[i].a, vt[i].d, rd, lat);
            chk($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vt[i].exp));
            chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd3);
        end
        @(negedge clk);
        chk("single_pulse", 64'(resp_valid), 64'd0);
        chk("tx_valid_41", 64'(tx_valid), 64'd1);
        chk("tx_data_41", 64'(tx_data), 64'h41);

        // Fill to 16 entries, then a 17th write must stall
        for (int i = 0; i < 15; i++) xact(1'b1, 64'hA000_03F8, 32'(8'h42 + i), rd, lat);
        xact(1'b0, 64'hA000_03FC, 0, rd, lat);
        chk("stat_full", 64'(rd), 64'h0000_1001);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'hA000_03F8; req_wdata = 32'h51;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("stall_no_resp", 64'(seen), 64'd0);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (resp_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("stall_resp", 64'(seen), 64'd1);
        chk("head_after_pop", 64'(tx_data), 64'h42);
        xact(1'b0, 64'hA000_03FC, 0, rd, lat);
        chk("stat_still_full", 64'(rd), 64'h0000_1001);

        // Drain in order
        @(negedge clk);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'(8'h42 + i) : 8'h51;
            chk($sformatf("drain%0d", i), 64'({tx_valid, tx_data}), 64'({1'b1, exp_b}));
            @(negedge clk);
        end
        chk("drained_empty", 64'(tx_valid), 64'd0);
        tx_ready = 1'b0;

        // Wrong region and unmapped
        xact(1'b0, 64'h8000_1000, 0, rd, lat);
        chk("badreg_rdata", 64'(rd), 64'd0);
        chk("badreg_lat", 64'(lat), 64'd3);
        xact(1'b1, 64'h8000_03F8, 32'h99, rd, lat);
        xact(1'b0, 64'hA000_03FC, 0, rd, lat);
        chk("stat_err", 64'(rd), 64'h0000_0006);
        xact(1'b0, 64'hA000_0100, 0, rd, lat);
        chk("unmapped", 64'(rd), 64'd0);

        // Reset during WAIT
        xact(1'b1, 64'hA000_03F8, 32'h77, rd, lat);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'hA000_03FC;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        chk("rst_abort_noresp", 64'(seen), 64'd0);
        chk("rst_abort_idle", 64'(ready_to_read), 64'd1);
        chk("rst_abort_empty", 64'(tx_valid), 64'd0);
        xact(1'b0, 64'hA000_03FC, 0, rd, lat);
        chk("rst_abort_stat", 64'(rd), 64'h0000_0002);

        // Timer rate after a fresh reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4000) @(posedge clk);
        xact(1'b0, 64'hA000_0048, 0, rd, lat);
        chk("time_lo_range", 64'(rd >= 32'd998 && rd <= 32'd1002), 64'd1);
        xact(1'b0, 64'hA000_004C, 0, rd, lat);
        chk("time_hi_zero", 64'(rd), 64'd0);

        // Low-word carry into the high word, then snapshot stability
        @(negedge clk);
        force dut.timer_q = 64'h0000_0000_FFFF_FFFF;
        force dut.pre_q   = 2'd3;
        #1;
        release dut.timer_q;
        release dut.pre_q;
        @(posedge clk);
        xact(1'b0, 64'hA000_0048, 0, rd, lat);
        chk("time_lo_wrap", 64'(rd), 64'd0);
        repeat (20) @(posedge clk);
        xact(1'b0, 64'hA000_004C, 0, rd, lat);
        chk("time_hi_shadow", 64'(rd), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Device-side responder for the LSU MMIO request channel (region addr[31:28]==4'hA).
- Accepts level-held requests and returns a one-cycle response pulse with registered read data.
- Hosts two devices:
  - a UART transmit FIFO, drained through a byte stream port;
  - a 64-bit prescaled timer with a snapshot-on-low-read.
- Sits between the LSU MMIO port and the SoC peripheral pins/console model.

Parameters:
- RESP_LAT, 1, extra wait cycles between request accept and response (0..15).
- FIFO_DEPTH, 16, UART TX FIFO entries (power of two, ≥2).
- PRESCALE, 100, clk cycles per timer increment (≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present; held high until resp_valid seen
- req_write  in  1  1=write, 0=read
- req_addr  in  64  byte address
- req_wdata  in  32  write data
- req_size  in  4  access size; recorded, accesses treated as 32-bit
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  read data; registered, held until next response
- ready_to_read  out  1  high in IDLE (responder can accept)
- tx_valid  out  1  FIFO head byte available
- tx_data  out  8  FIFO head byte
- tx_ready  in  1  consumer takes byte when tx_valid&&tx_ready

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; resp_valid=0; resp_rdata=0; FIFO empty (tx_valid=0, tx_data=0).
  - Timer=0, prescale counter=0, shadow=0, err sticky=0.
  - Reset mid-transaction aborts it; no response is issued.
- FSM:
  - IDLE: on req_valid, latch write/addr/wdata/size, load wait counter=RESP_LAT. Go to WAIT if RESP_LAT>0, else EXEC.
  - WAIT: decrement the counter each cycle; at 0, go to EXEC.
  - EXEC: perform the access; go to RESP. A UART write with FIFO full stays in EXEC until a slot frees (backpressure).
  - RESP: resp_valid=1 for exactly one cycle; resp_rdata updated on the EXEC→RESP edge; return to IDLE.
- ready_to_read=1 only in IDLE. A request still high in the IDLE cycle after RESP is treated as a new request: the initiator drops or replaces it on the resp_valid cycle.
- Request latency: RESP_LAT+2 cycles from accept to resp_valid (no stall).
- Register map (offset = req_addr[11:0], word-aligned; addr[1:0] ignored):
  - 0x3F8 UART_DATA: write pushes wdata[7:0]; read returns 0.
  - 0x3FC UART_STAT (read-only):
    - bit0 = full
    - bit1 = empty
    - bit2 = err sticky
    - bits[15:8] = FIFO count
  - 0x048 TIME_LO: read returns timer[31:0] and latches timer[63:32] into shadow in the same cycle.
  - 0x04C TIME_HI: read returns shadow.
  - Writes to TIME_*/UART_STAT are ignored.
- Unmapped offset: read returns 0, write ignored, still responds normally.
- req_addr[31:28]!=4'hA: full handshake, read 0, no side effects, err sticky set. The err bit clears only on reset.
- FIFO:
  - circular, wrap-around pointers with an extra MSB for full/empty.
  - Push and pop in the same cycle when full or when non-empty: count unchanged.
  - Push on empty with tx_ready high: the byte appears on tx_valid the next cycle (no bypass).
  - tx_data = head entry; it is 0 when empty.
- Timer:
  - Prescale counter runs 0..PRESCALE-1; at PRESCALE-1 it wraps and the timer increments.
  - Timer wraps at 2^64-1 → 0.
  - The timer runs continuously, independent of the FSM.

Test Plan:
- Reset then idle: resp_valid=0, ready_to_read=1, tx_valid=0, read UART_STAT (0xA00003FC) → 0x00000002.
- Write 0x41 to 0xA00003F8 with RESP_LAT=1, tx_ready=0: resp_valid at cycle 3 after accept; tx_valid=1, tx_data=0x41; UART_STAT → 0x00000100.
- Push 16 bytes with tx_ready=0; a 17th write stalls in EXEC, no resp_valid. Raise tx_ready for 1 cycle: the 17th completes, count stays 16, full=1.
- PRESCALE=4, run 4000 cycles after reset, read TIME_LO → ~1000 (±2). Force the timer to 0x00000000_FFFFFFFF with prescale counter at 3 and read TIME_LO → 0x00000000. The following TIME_HI read → 0x00000001, even after further ticks.
- Read 0x80001000 (wrong region): response 0, UART_STAT bit2=1 afterwards. Read unmapped 0xA0000100 → 0.
- Assert rst_n=0 during WAIT: no resp_valid; after release, the FSM is in IDLE and the FIFO is empty.
